// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller with a shadow/active word pair,
// per-slot dead time and optional leading-zero blanking.
module seg_scan_ctrl #(
    parameter logic [15:0] TICK_DIV  = 16'd2500,
    parameter logic [3:0]  BLANK_CYC = 4'd2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [15:0] ld_data,
    input  logic [3:0]  ld_dp,
    input  logic        lz_en,
    output logic [3:0]  hex_out,
    output logic        dp_out,
    output logic [3:0]  dig_sel,
    output logic        frame_strb
);

    localparam logic [15:0] SlotEnd  = TICK_DIV - 16'd1;
    localparam logic [15:0] BlankEnd = {12'd0, BLANK_CYC} - 16'd1;
    localparam bit          HasBlank = (BLANK_CYC != 4'd0);

    typedef enum logic [1:0] {StIdle, StBlank, StDrive} state_e;

    localparam state_e SlotStart = HasBlank ? StBlank : StDrive;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  idx_q, idx_d;

    logic [15:0] shd_data_q;
    logic [3:0]  shd_dp_q;
    logic        pending_q, pending_d;
    logic [15:0] act_data_q, act_data_d;
    logic [3:0]  act_dp_q, act_dp_d;

    logic [3:0]  hex_q, hex_d;
    logic        dp_q, dp_d;
    logic [3:0]  sel_q, sel_d;
    logic        frame_q, frame_d;

    logic        accept;
    logic        xfer;
    logic [3:0]  nib_zero;
    logic [3:0]  blank;

    // ------------------------------------------------------------------
    // Word storage and handshake
    // ------------------------------------------------------------------
    assign ld_ready = !pending_q;
    assign accept   = ld_valid && ld_ready;
    // Scanning: transfer only at the frame boundary so a frame never mixes two words.
    assign xfer     = pending_q && (en ? frame_q : 1'b1);

    always_comb begin
        act_data_d = act_data_q;
        act_dp_d   = act_dp_q;
        if (xfer) begin
            act_data_d = shd_data_q;
            act_dp_d   = shd_dp_q;
        end
        pending_d = accept || (pending_q && !xfer);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shd_data_q <= '0;
            shd_dp_q   <= '0;
            pending_q  <= 1'b0;
            act_data_q <= '0;
            act_dp_q   <= '0;
        end else begin
            if (accept) begin
                shd_data_q <= ld_data;
                shd_dp_q   <= ld_dp;
            end
            pending_q  <= pending_d;
            act_data_q <= act_data_d;
            act_dp_q   <= act_dp_d;
        end
    end

    // ------------------------------------------------------------------
    // Slot sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (!en) begin
            state_d = StIdle;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_d = SlotStart;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
                StBlank, StDrive: begin
                    if (cnt_q == SlotEnd) begin
                        state_d = SlotStart;
                        cnt_d   = '0;
                        idx_d   = idx_q + 2'd1;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                        if (state_q == StBlank && cnt_q == BlankEnd) begin
                            state_d = StDrive;
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero blanking, evaluated on the word the next cycle will show
    // ------------------------------------------------------------------
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            nib_zero[k] = (act_data_d[4*k +: 4] == 4'h0);
        end
        blank[3] = lz_en && nib_zero[3];
        blank[2] = blank[3] && nib_zero[2];
        blank[1] = blank[2] && nib_zero[1];
        blank[0] = 1'b0;
    end

    // ------------------------------------------------------------------
    // Registered outputs, computed from the next sequencer state so they line up with it
    // ------------------------------------------------------------------
    always_comb begin
        hex_d   = hex_q;
        dp_d    = dp_q;
        sel_d   = '0;
        frame_d = 1'b0;
        if (state_d == StDrive) begin
            hex_d = act_data_d[{idx_d, 2'b00} +: 4];
            dp_d  = act_dp_d[idx_d];
            if (!blank[idx_d]) begin
                sel_d = 4'b0001 << idx_d;
            end
        end
        if (state_d != StIdle && cnt_d == SlotEnd && idx_d == 2'd3) begin
            frame_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_q   <= '0;
            dp_q    <= 1'b0;
            sel_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            hex_q   <= hex_d;
            dp_q    <= dp_d;
            sel_q   <= sel_d;
            frame_q <= frame_d;
        end
    end

    assign hex_out    = hex_q;
    assign dp_out     = dp_q;
    assign dig_sel    = sel_q;
    assign frame_strb = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomised scoreboard bench for seg_scan_ctrl: a frame-arithmetic reference model pushes
// expected outputs per cycle; an independent monitor pops and compares on the falling edge.
module tb_seg_scan_ctrl;

    localparam int TD = 8;
    localparam int BC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        ld_valid;
    logic        ld_ready;
    logic [15:0] ld_data;
    logic [3:0]  ld_dp;
    logic        lz_en;
    logic [3:0]  hex_out;
    logic        dp_out;
    logic [3:0]  dig_sel;
    logic        frame_strb;

    seg_scan_ctrl #(
        .TICK_DIV  (16'd8),
        .BLANK_CYC (4'd2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_data    (ld_data),
        .ld_dp      (ld_dp),
        .lz_en      (lz_en),
        .hex_out    (hex_out),
        .dp_out     (dp_out),
        .dig_sel    (dig_sel),
        .frame_strb (frame_strb)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ready;
        logic       frame;
        logic [3:0] sel;
        logic [3:0] hex;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model: position in the scan is just a cycle count since scanning began.
    bit          m_scan;
    int          m_t;
    logic [15:0] m_act, m_shd;
    logic [3:0]  m_act_dp, m_shd_dp;
    bit          m_pend;
    logic [3:0]  m_hex, m_sel;
    logic        m_dp, m_frame;

    function automatic int cur_slot();
        return (m_t / TD) % 4;
    endfunction

    function automatic int cur_pos();
        return m_t % TD;
    endfunction

    task automatic model_reset();
        m_scan = 0; m_t = 0;
        m_act = '0; m_shd = '0; m_act_dp = '0; m_shd_dp = '0; m_pend = 0;
        m_hex = '0; m_sel = '0; m_dp = 1'b0; m_frame = 1'b0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.ready = !m_pend;
        e.frame = m_frame;
        e.sel   = m_sel;
        e.hex   = m_hex;
        e.dp    = m_dp;
        exp_q.push_back(e);
    endtask

    task automatic model_edge();
        bit accept, xfer;
        int slot, pos;
        logic [15:0] upper;
        accept = ld_valid && !m_pend;
        xfer   = m_pend && (en ? m_frame : 1'b1);
        if (xfer) begin
            m_act = m_shd; m_act_dp = m_shd_dp; m_pend = 0;
        end
        if (accept) begin
            m_shd = ld_data; m_shd_dp = ld_dp; m_pend = 1;
        end
        if (!en) m_scan = 0;
        else if (!m_scan) begin m_scan = 1; m_t = 0; end
        else m_t++;
        m_sel   = '0;
        m_frame = 1'b0;
        if (m_scan) begin
            slot  = cur_slot();
            pos   = cur_pos();
            upper = m_act >> (4 * slot);
            if (pos >= BC) begin
                m_hex = 4'(upper & 16'hF);
                m_dp  = m_act_dp[slot];
                if (!(lz_en && slot != 0 && upper == 16'h0)) m_sel = 4'(1 << slot);
            end
            m_frame = (pos == TD - 1) && (slot == 3);
        end
    endtask

    // One clock: model the edge, publish expectation, then leave 1 time unit for new drive.
    task automatic step();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        push_exp();
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Reset raised between edges; the monitor samples before any further edge.
    task automatic reset_pulse();
        @(posedge clk);
        #2 reset = 1'b1;
        model_reset();
        push_exp();
        #5 reset = 1'b0;
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] dp);
        ld_valid = 1'b1; ld_data = d; ld_dp = dp;
        for (int i = 0; i < 200 && m_pend; i++) step();
        step();
        ld_valid = 1'b0;
    endtask

    task automatic run_until_drive(input int slot);
        for (int i = 0; i < 100; i++) begin
            if (m_scan && cur_slot() == slot && cur_pos() >= BC + 1) break;
            step();
        end
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ld_ready",   {3'b0, ld_ready},   {3'b0, e.ready});
            check("frame_strb", {3'b0, frame_strb}, {3'b0, e.frame});
            check("dig_sel",    dig_sel,            e.sel);
            check("hex_out",    hex_out,            e.hex);
            check("dp_out",     {3'b0, dp_out},     {3'b0, e.dp});
        end
    end

    initial begin
        logic [15:0] d;
        reset = 1'b1; en = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_dp = '0; lz_en = 1'b0;
        model_reset();
        step();
        reset = 1'b0;
        run(2);

        // Idle load, then a plain scan of 1234
        load(16'h1234, 4'b0100);
        run(3);
        en = 1'b1;
        run(70);

        // Mid-frame load must wait for the frame boundary
        load(16'hABCD, 4'b1001);
        run(80);

        // Leading-zero blanking
        lz_en = 1'b1;
        load(16'h0040, 4'b1010);
        run(70);
        load(16'h0000, 4'b0001);
        run(70);
        lz_en = 1'b0;

        // Enable drop during slot-2 drive, then restart
        run_until_drive(2);
        en = 1'b0;
        run(3);
        en = 1'b1;
        run(40);

        // Async reset in the middle of a drive phase
        run_until_drive(1);
        reset_pulse();
        run(20);
        load(16'h5678, 4'b0011);
        run(40);

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 2) en = ~en;
            if ($urandom_range(0, 99) == 0) lz_en = ~lz_en;
            ld_valid = ($urandom_range(0, 15) == 0);
            for (int k = 0; k < 4; k++) begin
                d[4*k +: 4] = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            end
            ld_data = d;
            ld_dp   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 999) == 0) reset_pulse();
            else step();
        end
        ld_valid = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 16'd2500: number of clk cycles in each digit slot; legal range is BLANK_CYC+1 to 65535.
REQ-002 Parameter BLANK_CYC, default 4'd2: dead-time cycles at the start of each slot, during which no digit is driven.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  scan enable; 0 forces the IDLE state.
REQ-006 ld_valid  input  1  a new display word is offered.
REQ-007 ld_ready  output  1  the controller can accept a word.
REQ-008 ld_data  input  16  four hex nibbles; nibble k (bits 4k+3:4k) goes to digit k, and digit 0 is least significant.
REQ-009 ld_dp  input  4  decimal-point enable per digit.
REQ-010 lz_en  input  1  leading-zero blanking enable; sampled live.
REQ-011 hex_out  output  4  nibble for the shared 7-segment decoder; registered.
REQ-012 dp_out  output  1  decimal point for the current slot; registered.
REQ-013 dig_sel  output  4  one-hot active-high digit strobe, or all zeros; registered.
REQ-014 frame_strb  output  1  one-cycle pulse on the last cycle of slot 3.

Function
REQ-015 Storage: a shadow register (16+4 bits) plus a pending flag, and an active register (16+4 bits) that drives the display.
REQ-016 Handshake: a word is accepted when ld_valid and ld_ready are both 1 on a clock edge; ld_ready = !pending, combinational from the flag.
REQ-017 On acceptance, ld_data and ld_dp are written to the shadow register and pending is set.
REQ-018 While en=1, shadow is copied to active, and pending is cleared, only on a cycle where frame_strb=1; this prevents tearing.
REQ-019 While en=0, a pending shadow word is copied to active on the next edge.
REQ-020 No acceptance can coincide with pending=1, because ld_ready is 0.
REQ-021 Acceptance in the frame_strb cycle with pending=0: the word goes to shadow only and is transferred at the following frame boundary.
REQ-022 FSM states: IDLE, BLANK, DRIVE. The slot counter cnt is 16 bits; the slot index idx is 2 bits.
REQ-023 IDLE: cnt=0, idx=0, dig_sel=0, frame_strb=0. The FSM leaves IDLE for BLANK on the first edge with en=1.
REQ-024 BLANK: dig_sel=0 and cnt increments each cycle. When cnt reaches BLANK_CYC-1 the FSM moves to DRIVE; if BLANK_CYC=0, it enters DRIVE directly from slot start.
REQ-025 DRIVE: cnt increments each cycle, and dig_sel = 1<<idx unless digit idx is blanked.
REQ-026 Slot end is at cnt = TICK_DIV-1. Then cnt becomes 0, idx increments modulo 4 (3 wraps to 0), and the FSM returns to BLANK.
REQ-027 frame_strb is asserted exactly on the slot-end cycle where idx=3.
REQ-028 hex_out and dp_out carry active nibble idx and dp bit idx, and are updated on the same edge as dig_sel.
REQ-029 hex_out and dp_out hold their values in BLANK and IDLE.
REQ-030 Blanking rule: with lz_en=1, digit k (k=3..1) is blanked when active nibbles 3 down to k are all zero. Digit 0 is never blanked.
REQ-031 A blanked slot keeps full timing and drives dig_sel=0; dp_out still follows ld_dp.
REQ-032 en deasserted in any state: the FSM enters IDLE on the next edge and all outputs are forced to IDLE values; pending and shadow contents are kept.

Reset
REQ-033 On reset, the FSM goes to IDLE with cnt=0 and idx=0.
REQ-034 On reset, the active register, shadow register and pending are cleared, so ld_ready=1.
REQ-035 On reset, hex_out=0, dp_out=0, dig_sel=0 and frame_strb=0. Reset asserted mid-slot takes effect immediately, without a clock edge.

Verification (TICK_DIV=8, BLANK_CYC=2)
REQ-036 Scan timing: en=1 with active word 16'h1234 -> each slot lasts 8 cycles with dig_sel=0 for 2 cycles then 6 cycles lit. dig_sel runs 0001, 0010, 0100, 1000 with hex_out 4, 3, 2, 1. frame_strb pulses every 32 cycles.
REQ-037 Boundary-only update: a load of 16'hABCD mid-frame -> ld_ready=0 until frame_strb; the display changes only from the slot-0 that follows, and ld_ready returns to 1 the cycle after frame_strb.
REQ-038 Leading-zero blanking: word 16'h0040, lz_en=1 -> slots 3 and 2 show dig_sel=0, slot 1 lit with 4, slot 0 lit with 0. Word 16'h0000 -> only digit 0 is lit.
REQ-039 Enable drop: en=0 during a slot-2 DRIVE -> dig_sel=0 and idx=0 on the next edge. Re-enabling starts at slot 0 BLANK.
REQ-040 Idle load: en=0, load 16'h5678 -> active register updated one cycle after acceptance, and ld_ready=1 again.
REQ-041 Async reset: reset pulsed mid-DRIVE between edges -> all outputs 0 immediately, and ld_ready=1.
